// File: rtl/if_prefetch.sv
// if_prefetch: sequential instruction-fetch stage with a DEPTH-entry prefetch queue.
// Issues word loads to the memory controller, buffers {pc, instruction} pairs and
// hands them to ID over a valid/ready handshake. A redirect flushes the queue and
// throws away the response of any request still in flight.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-high reset
//   rdy_in                  global enable; low freezes every register
//   memctl_op/len/addr      load request to the memory controller
//   memctl_rdy/out          one-cycle response strobe and fetched word
//   br_flag/br_target       redirect request and new PC from EX
//   id_ready                ID takes the head entry this cycle
//   out_valid/output_pc/ins head entry of the queue
//   stall                   STALL_IF while the queue is empty
//
// state   | meaning
// IDLE    | no request outstanding (queue full, or one cycle after redirect/discard)
// REQ     | load at fetch_pc outstanding; its data will be queued
// DISCARD | load outstanding but abandoned by a redirect; its data is dropped
module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic [1:0]  memctl_op,
    output logic [1:0]  memctl_len,
    output logic [31:0] memctl_addr,
    input  logic        memctl_rdy,
    input  logic [31:0] memctl_out,
    input  logic        br_flag,
    input  logic [31:0] br_target,
    input  logic        id_ready,
    output logic        out_valid,
    output logic [31:0] output_pc,
    output logic [31:0] ins,
    output logic [2:0]  stall
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] MEM_NOP  = 2'b00;
    localparam logic [1:0] MEM_LOAD = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [2:0] STALL_IF = 3'b001;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    state_t         r_state;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_addr;
    logic [CW-1:0]  r_count;
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [31:0]    r_last_pc;
    logic [31:0]    r_last_ins;
    logic [31:0]    r_q_pc  [DEPTH];
    logic [31:0]    r_q_ins [DEPTH];

    logic           w_empty;
    logic           w_pop;
    logic           w_push;
    logic [CW-1:0]  w_next_count;

    assign w_empty      = (r_count == '0);
    assign w_pop        = !w_empty && id_ready;
    // Space is guaranteed: a request is only issued while count < DEPTH.
    assign w_push       = (r_state == S_REQ) && memctl_rdy && !br_flag;
    assign w_next_count = r_count + CW'(w_push) - CW'(w_pop);

    // Queue storage carries no control meaning, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && w_push) begin
            r_q_pc[r_tail]  <= r_fetch_pc;
            r_q_ins[r_tail] <= memctl_out;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= 32'h0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_last_pc  <= 32'h0;
            r_last_ins <= 32'h0;
        end else if (rdy_in) begin
            // Remember the head so the outputs hold once the queue drains or flushes.
            if (!w_empty) begin
                r_last_pc  <= r_q_pc[r_head];
                r_last_ins <= r_q_ins[r_head];
            end
            if (br_flag) begin
                r_count    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_fetch_pc <= br_target;
                // r_addr is left alone: DISCARD keeps presenting the abandoned address.
                case (r_state)
                    S_REQ:     r_state <= memctl_rdy ? S_IDLE : S_DISCARD;
                    S_DISCARD: r_state <= memctl_rdy ? S_IDLE : S_DISCARD;
                    default:   r_state <= S_IDLE;
                endcase
            end else begin
                r_count <= w_next_count;
                if (w_pop) begin
                    r_head <= r_head + PTR_ONE;
                end
                if (w_push) begin
                    r_tail     <= r_tail + PTR_ONE;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                case (r_state)
                    S_IDLE: begin
                        if (r_count < CNT_DEPTH) begin
                            r_state <= S_REQ;
                            r_addr  <= r_fetch_pc;
                        end
                    end
                    S_REQ: begin
                        if (memctl_rdy) begin
                            if (w_next_count < CNT_DEPTH) begin
                                r_addr <= r_fetch_pc + 32'd4;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_DISCARD: begin
                        if (memctl_rdy) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign memctl_op   = (r_state == S_IDLE) ? MEM_NOP : MEM_LOAD;
    assign memctl_len  = MEM_WORD;
    assign memctl_addr = r_addr;
    assign out_valid   = !w_empty;
    assign output_pc   = w_empty ? r_last_pc  : r_q_pc[r_head];
    assign ins         = w_empty ? r_last_ins : r_q_ins[r_head];
    assign stall       = w_empty ? STALL_IF : 3'b000;

endmodule

// File: tb/tb_if_prefetch.sv
// Testbench for if_prefetch: a memory-controller model with programmable latency,
// a queue-level reference model checked every cycle, and directed scenarios with
// hand-computed literal expectations.
module tb_if_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [1:0]  MEM_NOP  = 2'b00;
    localparam logic [1:0]  MEM_LOAD = 2'b01;
    localparam logic [1:0]  MEM_WORD = 2'b10;
    localparam logic [2:0]  STALL_IF = 3'b001;
    localparam int          BUDGET   = 300;

    logic        clk_in, rst_in, rdy_in;
    logic [1:0]  memctl_op, memctl_len;
    logic [31:0] memctl_addr;
    logic        memctl_rdy;
    logic [31:0] memctl_out;
    logic        br_flag;
    logic [31:0] br_target;
    logic        id_ready;
    logic        out_valid;
    logic [31:0] output_pc, ins;
    logic [2:0]  stall;

    int checks = 0;
    int errors = 0;

    if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .memctl_op(memctl_op), .memctl_len(memctl_len), .memctl_addr(memctl_addr),
        .memctl_rdy(memctl_rdy), .memctl_out(memctl_out),
        .br_flag(br_flag), .br_target(br_target), .id_ready(id_ready),
        .out_valid(out_valid), .output_pc(output_pc), .ins(ins), .stall(stall)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired at %0t", name, $time);
    endtask

    // Memory controller: latches the address of a new load and answers lat cycles later.
    int          lat = 2;
    bit          mem_busy;
    bit          mem_act;
    int          mem_cnt;
    logic [31:0] mem_req_addr;
    logic [31:0] req_log[$];

    initial begin
        memctl_rdy = 1'b0;
        memctl_out = 32'h0;
        mem_busy   = 1'b0;
        forever begin
            @(posedge clk_in);
            mem_act = rdy_in && !rst_in;
            #1;
            if (rst_in) begin
                mem_busy   = 1'b0;
                memctl_rdy = 1'b0;
            end else if (mem_act) begin
                memctl_rdy = 1'b0;
                if (mem_busy) chk("addr_stable", memctl_addr, mem_req_addr);
                if (!mem_busy && memctl_op == MEM_LOAD) begin
                    mem_busy     = 1'b1;
                    mem_cnt      = lat;
                    mem_req_addr = memctl_addr;
                    req_log.push_back(memctl_addr);
                end
                if (mem_busy) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        memctl_rdy = 1'b1;
                        memctl_out = memword(mem_req_addr);
                        mem_busy   = 1'b0;
                    end
                end
            end
        end
    end

    // Reference model: the queue as a list of {pc, word}, the next fetch pc, and
    // whether the next response belongs to a request abandoned by a redirect.
    ent_t        mq[$];
    ent_t        got[$];
    logic [31:0] m_fpc, m_last_pc, m_last_ins;
    bit          m_discard;
    bit          m_pop, m_push;

    task automatic model_reset();
        mq.delete();
        m_fpc      = RESET_PC;
        m_last_pc  = 32'h0;
        m_last_ins = 32'h0;
        m_discard  = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in);
            if (rst_in) begin
                model_reset();
            end else if (rdy_in) begin
                if (br_flag) begin
                    mq.delete();
                    m_fpc     = br_target;
                    m_discard = mem_busy;
                end else begin
                    m_pop  = (mq.size() != 0) && id_ready;
                    m_push = memctl_rdy && !m_discard;
                    if (memctl_rdy && m_discard) m_discard = 1'b0;
                    if (m_pop) void'(mq.pop_front());
                    if (m_push) begin
                        mq.push_back('{pc: m_fpc, ins: memword(m_fpc)});
                        m_fpc = m_fpc + 32'd4;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_in) model_reset();
            chk("stall", stall, (mq.size() == 0) ? STALL_IF : 3'b000);
            chk("out_valid", out_valid, (mq.size() != 0) ? 1 : 0);
            chk("len", memctl_len, MEM_WORD);
            if (mq.size() != 0) begin
                chk("head_pc", output_pc, mq[0].pc);
                chk("head_ins", ins, mq[0].ins);
                m_last_pc  = mq[0].pc;
                m_last_ins = mq[0].ins;
            end else begin
                chk("hold_pc", output_pc, m_last_pc);
                chk("hold_ins", ins, m_last_ins);
            end
            if (mq.size() == DEPTH) chk("op_full", memctl_op, MEM_NOP);
            if (memctl_op == MEM_LOAD && !m_discard) chk("fetch_addr", memctl_addr, m_fpc);
            if (out_valid && id_ready && rdy_in && !br_flag && !rst_in)
                got.push_back('{pc: output_pc, ins: ins});
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic do_reset();
        rst_in   = 1'b1;
        br_flag  = 1'b0;
        id_ready = 1'b0;
        rdy_in   = 1'b1;
        repeat (2) tick();
        req_log.delete();
        got.delete();
        rst_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          n, r, ng;
    bit          found;
    logic [31:0] save_addr, save_pc;

    initial begin
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        br_flag   = 1'b0;
        br_target = 32'h0;
        id_ready  = 1'b0;

        // Reset state
        lat = 2;
        repeat (2) tick();
        chk("rst_op", memctl_op, MEM_NOP);
        chk("rst_addr", memctl_addr, 32'h0);
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", output_pc, 32'h0);
        chk("rst_ins", ins, 32'h0);
        chk("rst_stall", stall, STALL_IF);

        // 1: 2-cycle memory, ID always ready
        do_reset();
        id_ready = 1'b1;
        tick(); tick();
        chk("t1_stall_before", stall, STALL_IF);
        tick();
        chk("t1_stall_after", stall, 3'b000);
        n = 0;
        while (got.size() < 2 && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) timeout("t1_wait");
        else begin
            chk("t1_req0", req_log[0], 32'h0);
            chk("t1_req1", req_log[1], 32'h4);
            chk("t1_req2", req_log[2], 32'h8);
            chk("t1_pc0", got[0].pc, 32'h0);
            chk("t1_ins0", got[0].ins, 32'hC0DE_0000);
            chk("t1_pc1", got[1].pc, 32'h4);
            chk("t1_ins1", got[1].ins, 32'hC0DE_0004);
        end

        // 2: queue fills with ID stalled, one pop refetches at 0x10
        lat = 1;
        do_reset();
        n = 0;
        while (mq.size() < DEPTH && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) timeout("t2_fill");
        tick(); tick();
        chk("t2_op_nop", memctl_op, MEM_NOP);
        chk("t2_valid", out_valid, 1);
        chk("t2_head_pc", output_pc, 32'h0);
        chk("t2_nreq", req_log.size(), 4);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        n = 0;
        while (req_log.size() < 5 && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) timeout("t2_refetch");
        else chk("t2_req_0x10", req_log[4], 32'h10);

        // 3: redirect to 0x100 while the load at 0x8 is pending
        lat = 3;
        do_reset();
        id_ready = 1'b1;
        n = 0;
        while (!(mem_busy && mem_req_addr == 32'h8) && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) timeout("t3_pending");
        br_flag   = 1'b1;
        br_target = 32'h100;
        tick();
        br_flag = 1'b0;
        chk("t3_discard_op", memctl_op, MEM_LOAD);
        chk("t3_discard_addr", memctl_addr, 32'h8);
        ng = got.size();
        r  = req_log.size();
        n  = 0;
        while (got.size() <= ng && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) timeout("t3_first_after");
        else begin
            chk("t3_req_after", req_log[r], 32'h100);
            chk("t3_pc_after", got[ng].pc, 32'h100);
            chk("t3_ins_after", got[ng].ins, 32'hC0DE_0100);
        end
        found = 1'b0;
        foreach (got[i]) if (got[i].pc == 32'h8) found = 1'b1;
        chk("t3_no_0x8", found, 0);

        // 4: redirect together with a response and a pop, two entries queued
        lat = 2;
        do_reset();
        n = 0;
        while (!(mq.size() == 2 && memctl_rdy) && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) timeout("t4_setup");
        id_ready  = 1'b1;
        br_flag   = 1'b1;
        br_target = 32'h200;
        tick();
        br_flag  = 1'b0;
        id_ready = 1'b0;
        chk("t4_valid", out_valid, 0);
        chk("t4_stall", stall, STALL_IF);
        chk("t4_op_idle", memctl_op, MEM_NOP);
        r = req_log.size();
        n = 0;
        while (req_log.size() <= r && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) timeout("t4_refetch");
        else chk("t4_req_target", req_log[r], 32'h200);

        // 5: rdy_in low for five cycles mid-stream
        lat = 2;
        do_reset();
        id_ready = 1'b1;
        n = 0;
        while (got.size() < 2 && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) timeout("t5_stream");
        save_addr = memctl_addr;
        save_pc   = output_pc;
        rdy_in    = 1'b0;
        repeat (5) begin
            tick();
            chk("t5_addr_frozen", memctl_addr, save_addr);
            chk("t5_pc_frozen", output_pc, save_pc);
        end
        rdy_in = 1'b1;
        n = 0;
        while (got.size() < 6 && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) timeout("t5_resume");
        else chk("t5_pc5", got[5].pc, 32'h14);

        // 6: asynchronous reset with three entries queued and a load outstanding
        lat = 3;
        do_reset();
        n = 0;
        while (!(mq.size() == 3 && memctl_op == MEM_LOAD) && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) timeout("t6_setup");
        #1;
        rst_in = 1'b1;
        #1;
        chk("t6_async_op", memctl_op, MEM_NOP);
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_stall", stall, STALL_IF);
        tick(); tick();
        req_log.delete();
        got.delete();
        rst_in   = 1'b0;
        id_ready = 1'b1;
        n = 0;
        while (got.size() < 1 && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) timeout("t6_restart");
        else begin
            chk("t6_req_reset_pc", req_log[0], RESET_PC);
            chk("t6_first_pc", got[0].pc, RESET_PC);
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
